// File: rtl/frigate_adc_pkg.sv
// Shared types and widths for the Frigate SAR ADC controller.
package frigate_adc_pkg;

    localparam int ADC_BITS   = 12;
    localparam int ADC_CHAN_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } adc_state_t;

endpackage

// File: rtl/frigate_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module frigate_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/frigate_adc_sar_ctrl.sv
// SAR ADC conversion sequencer: sample, 12 binary-search bit trials, result.
// Optional build macro FRIGATE_ADC_CONT_EN adds a 'cont' input that chains
// conversions on the same channel without returning to IDLE.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | ADC off, waiting for start
// ST_SAMPLE  | ADC tracking input for SAMPLE_CYCLES (reset pulse in first)
// ST_CONVERT | input held, one bit trial every SETTLE_CYCLES+2 cycles
// ST_DONE    | one-cycle result strobe
//
// adc_data carries the code with bit 11 as MSB; the board wires bit 11 to
// the converter's DATA[0] pin.
module frigate_adc_sar_ctrl
    import frigate_adc_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADC_CHAN_W-1:0] chan,
`ifdef FRIGATE_ADC_CONT_EN
    input  logic                  cont,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADC_BITS-1:0]   result,
    output logic                  adc_en,
    output logic                  adc_rst,
    output logic                  adc_hold,
    output logic [ADC_CHAN_W-1:0] adc_b,
    output logic [ADC_BITS-1:0]   adc_data,
    input  logic                  adc_cmp
);

    // The two synchroniser flops eat two of each trial's cycles, so a trial
    // is SETTLE_CYCLES of real settling plus the synchroniser delay.
    localparam int         TRIAL_CYCLES = SETTLE_CYCLES + 2;
    localparam logic [7:0] SAMPLE_LOAD  = 8'(SAMPLE_CYCLES - 1);
    localparam logic [7:0] TRIAL_LOAD   = 8'(TRIAL_CYCLES - 1);

    adc_state_t            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [ADC_BITS-1:0]   code_q, code_d;
    logic [ADC_BITS-1:0]   result_q, result_d;
    logic [ADC_CHAN_W-1:0] chan_q, chan_d;
    logic [ADC_BITS-1:0]   decided;
    logic                  cmp_sync;

    frigate_sync2 u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_cmp),
        .q     (cmp_sync)
    );

    // State, timer, trial code, channel and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            code_q   <= '0;
            result_q <= '0;
            chan_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            code_q   <= code_d;
            result_q <= result_d;
            chan_q   <= chan_d;
        end
    end

    // Next-state logic: down-counter terminal count advances each phase.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        code_d   = code_q;
        result_d = result_q;
        chan_d   = chan_q;
        decided  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = SAMPLE_LOAD;
                    chan_d  = chan;
                    code_d  = '0;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_CONVERT;
                    cnt_d   = TRIAL_LOAD;
                    bit_d   = 4'(ADC_BITS - 1);
                    code_d  = 12'h800;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_CONVERT: begin
                if (cnt_q == 8'd0) begin
                    if (!cmp_sync) decided[bit_q] = 1'b0;
                    if (bit_q == 4'd0) begin
                        state_d  = ST_DONE;
                        code_d   = decided;
                        result_d = decided;
                    end else begin
                        bit_d  = bit_q - 4'd1;
                        code_d = decided | (12'h001 << (bit_q - 4'd1));
                        cnt_d  = TRIAL_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                code_d = '0;
                cnt_d  = '0;
                bit_d  = '0;
`ifdef FRIGATE_ADC_CONT_EN
                if (cont) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = SAMPLE_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign adc_en   = (state_q != ST_IDLE);
    assign adc_hold = (state_q == ST_CONVERT) || (state_q == ST_DONE);
    assign adc_rst  = (state_q == ST_SAMPLE) && (cnt_q == SAMPLE_LOAD);
    assign adc_b    = chan_q;
    assign adc_data = code_q;
    assign result   = result_q;

endmodule

// File: tb/tb_frigate_adc_sar_ctrl.sv
// Directed bench for frigate_adc_sar_ctrl with a comparator stub.
module tb_frigate_adc_sar_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  chan;
    logic        cont;
    logic        busy, done, adc_en, adc_rst, adc_hold, adc_cmp;
    logic [11:0] result, adc_data;
    logic [2:0]  adc_b;

    int          checks = 0;
    int          errors = 0;

    // 0: stub comparator, 1: stuck high, 2: stuck low
    int          mode;
    logic [11:0] vin;

    // Held input modelled half an LSB above vin, so "input exceeds DAC"
    // keeps every trial code <= vin and the search lands exactly on vin.
    assign adc_cmp = (mode == 1) ? 1'b1 :
                     (mode == 2) ? 1'b0 :
                     ({vin, 1'b1} > {adc_data, 1'b0});

    always #5 clk = ~clk;

    frigate_adc_sar_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .chan     (chan),
`ifdef FRIGATE_ADC_CONT_EN
        .cont     (cont),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .adc_en   (adc_en),
        .adc_rst  (adc_rst),
        .adc_hold (adc_hold),
        .adc_b    (adc_b),
        .adc_data (adc_data),
        .adc_cmp  (adc_cmp)
    );

    typedef struct {
        int          mode;
        logic [11:0] vin;
        logic [2:0]  ch;
        logic [11:0] exp_res;
        int          inject;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},     busy,     0);
        check({tag, " done"},     done,     0);
        check({tag, " result"},   result,   0);
        check({tag, " adc_en"},   adc_en,   0);
        check({tag, " adc_rst"},  adc_rst,  0);
        check({tag, " adc_hold"}, adc_hold, 0);
        check({tag, " adc_b"},    adc_b,    0);
        check({tag, " adc_data"}, adc_data, 0);
    endtask

    // One conversion; n counts rising edges after the accepting edge k.
    task automatic run_vec(input vec_t v);
        int first;
        int ndone;
        mode = v.mode;
        vin  = v.vin;
        first = -1;
        ndone = 0;
        @(negedge clk);
        start = 1'b1;
        chan  = v.ch;
        @(posedge clk);
        for (int n = 0; n < 66; n++) begin
            @(negedge clk);
            start = 1'b0;
            chan  = v.ch ^ 3'b111;
            if (n == v.inject) begin
                start = 1'b1;
                chan  = 3'd2;
            end
            if (n == 0) begin
                check("first sample busy", busy, 1);
                check("first sample adc_en", adc_en, 1);
                check("first sample adc_rst", adc_rst, 1);
                check("first sample adc_hold", adc_hold, 0);
            end
            if (n == 1) check("second sample adc_rst", adc_rst, 0);
            if (n == 8) begin
                check("convert adc_hold", adc_hold, 1);
                check("msb trial adc_data", adc_data, 12'h800);
                check("convert adc_b", adc_b, v.ch);
            end
            if (done) begin
                ndone++;
                if (first < 0) first = n;
                check("result at done", result, v.exp_res);
            end
            if (n == 57) begin
                check("idle busy", busy, 0);
                check("idle adc_en", adc_en, 0);
                check("idle adc_hold", adc_hold, 0);
                check("idle adc_data", adc_data, 0);
            end
        end
        check("done latency", first, 56);
        check("done pulse count", ndone, 1);
        check("held result", result, v.exp_res);
        check("adc_b after", adc_b, v.ch);
    endtask

    initial begin
        vecs[0] = '{0, 12'hA5C, 3'd5, 12'hA5C, -1};
        vecs[1] = '{0, 12'hA5C, 3'd5, 12'hA5C, 19};
        vecs[2] = '{1, 12'h000, 3'd3, 12'hFFF, -1};
        vecs[3] = '{2, 12'hFFF, 3'd6, 12'h000, -1};
        vecs[4] = '{0, 12'h000, 3'd7, 12'h000, -1};
        vecs[5] = '{0, 12'hFFF, 3'd1, 12'hFFF, -1};
        vecs[6] = '{0, 12'h800, 3'd0, 12'h800, -1};
        vecs[7] = '{0, 12'h7FF, 3'd2, 12'h7FF, -1};

        rst_n = 1'b0;
        start = 1'b0;
        chan  = 3'd0;
        cont  = 1'b0;
        mode  = 1;
        vin   = 12'h000;
        #23;
        check_all_zero("power-on reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // start held high: back-to-back conversions with one IDLE cycle
        begin
            int d0, d1, nd;
            d0 = -1; d1 = -1; nd = 0;
            mode = 0;
            vin  = 12'h123;
            @(negedge clk);
            start = 1'b1;
            chan  = 3'd1;
            @(posedge clk);
            for (int n = 0; n < 125; n++) begin
                @(negedge clk);
                if (n == 58) start = 1'b0;
                if (n == 57) check("b2b idle gap busy", busy, 0);
                if (n == 58) check("b2b restart busy", busy, 1);
                if (done) begin
                    nd++;
                    if (d0 < 0) d0 = n;
                    else if (d1 < 0) d1 = n;
                end
            end
            check("b2b first done", d0, 56);
            check("b2b second done", d1, 114);
            check("b2b done count", nd, 2);
            check("b2b result", result, 12'h123);
        end

        // asynchronous reset in the middle of CONVERT
        mode = 0;
        vin  = 12'h5A5;
        @(negedge clk);
        start = 1'b1;
        chan  = 3'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        check("pre-reset hold", adc_hold, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid-convert reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_vec('{0, 12'h3C5, 3'd4, 12'h3C5, -1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
